// File: rtl/snn_timestep_scheduler.sv
// Timestep sequencer for the SNN core: inject -> neuron-update sweep -> router drain,
// repeated up to a latched limit, with a drain watchdog and a one-cycle completion pulse.
module snn_timestep_scheduler #(
  parameter int NUM_NEURONS     = 256,
  parameter int NEURON_ID_WIDTH = $clog2(NUM_NEURONS),
  parameter int TIMESTEP_WIDTH  = 16,
  parameter int TIMEOUT_WIDTH   = 20
) (
  input  logic                       aclk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [TIMESTEP_WIDTH-1:0]  num_timesteps,
  input  logic [TIMEOUT_WIDTH-1:0]   drain_timeout,
  input  logic                       in_frame_last,
  output logic                       inject_en,
  output logic                       upd_valid,
  input  logic                       upd_ready,
  output logic [NEURON_ID_WIDTH-1:0] upd_id,
  output logic                       upd_last,
  input  logic                       router_empty,
  input  logic                       out_fifo_empty,
  output logic                       busy,
  output logic                       done_irq,
  output logic                       timeout_err,
  output logic [TIMESTEP_WIDTH-1:0]  cur_timestep,
  output logic [2:0]                 state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INJECT = 3'd1;
  localparam logic [2:0] S_UPDATE = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_STEP   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [NEURON_ID_WIDTH-1:0] LAST_ID = NEURON_ID_WIDTH'(NUM_NEURONS - 1);

  logic [2:0]                 state_q,       state_d;
  logic [NEURON_ID_WIDTH-1:0] upd_id_q,      upd_id_d;
  logic [TIMESTEP_WIDTH-1:0]  cur_ts_q,      cur_ts_d;
  logic [TIMESTEP_WIDTH-1:0]  limit_q,       limit_d;
  logic [TIMEOUT_WIDTH-1:0]   tmo_limit_q,   tmo_limit_d;
  logic [TIMEOUT_WIDTH-1:0]   tmo_cnt_q,     tmo_cnt_d;
  logic                       timeout_err_q, timeout_err_d;
  logic [TIMESTEP_WIDTH-1:0]  ts_inc;

  assign ts_inc = cur_ts_q + 1'b1;

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d       = state_q;
    upd_id_d      = upd_id_q;
    cur_ts_d      = cur_ts_q;
    limit_d       = limit_q;
    tmo_limit_d   = tmo_limit_q;
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        if (start && (num_timesteps != '0)) begin
          limit_d       = num_timesteps;
          tmo_limit_d   = drain_timeout;
          cur_ts_d      = '0;
          timeout_err_d = 1'b0;
          state_d       = S_INJECT;
        end
      end
      S_INJECT: begin
        if (in_frame_last) begin
          upd_id_d = '0;
          state_d  = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (upd_ready) begin
          if (upd_id_q == LAST_ID) begin
            // Index returns to 0 so upd_last never shows outside the sweep.
            upd_id_d  = '0;
            tmo_cnt_d = '0;
            state_d   = S_DRAIN;
          end else begin
            upd_id_d = upd_id_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (router_empty && out_fifo_empty) begin
          state_d = S_STEP;
        end else if ((tmo_limit_q != '0) && (tmo_cnt_q == tmo_limit_q - 1'b1)) begin
          timeout_err_d = 1'b1;
          state_d       = S_DONE;
        end
      end
      S_STEP: begin
        cur_ts_d = ts_inc;
        state_d  = (ts_inc == limit_q) ? S_DONE : S_INJECT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition and leaves the run's status untouched.
    if (abort && (state_q != S_IDLE)) begin
      state_d       = S_IDLE;
      upd_id_d      = '0;
      cur_ts_d      = cur_ts_q;
      timeout_err_d = timeout_err_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      upd_id_q      <= '0;
      cur_ts_q      <= '0;
      limit_q       <= '0;
      tmo_limit_q   <= '0;
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      upd_id_q      <= upd_id_d;
      cur_ts_q      <= cur_ts_d;
      limit_q       <= limit_d;
      tmo_limit_q   <= tmo_limit_d;
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign state        = state_q;
  assign inject_en    = (state_q == S_INJECT);
  assign upd_valid    = (state_q == S_UPDATE);
  assign upd_id       = upd_id_q;
  assign upd_last     = (upd_id_q == LAST_ID);
  assign busy         = (state_q != S_IDLE);
  assign done_irq     = (state_q == S_DONE);
  assign timeout_err  = timeout_err_q;
  assign cur_timestep = cur_ts_q;

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Directed bench for snn_timestep_scheduler (4 neurons): stimulus queues expected
// update ids and completion status; a negedge monitor pops and compares them.
module tb_snn_timestep_scheduler;

  localparam int NN  = 4;
  localparam int NIW = 2;
  localparam int TSW = 16;
  localparam int TOW = 20;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INJECT = 3'd1;
  localparam logic [2:0] S_UPDATE = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_STEP   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic           aclk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [TSW-1:0] num_timesteps = '0;
  logic [TOW-1:0] drain_timeout = '0;
  logic           in_frame_last = 1'b0;
  logic           upd_ready = 1'b1;
  logic           router_empty = 1'b1;
  logic           out_fifo_empty = 1'b1;
  logic           inject_en, upd_valid, upd_last, busy, done_irq, timeout_err;
  logic [NIW-1:0] upd_id;
  logic [TSW-1:0] cur_timestep;
  logic [2:0]     state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0;
  int upd_q[$];
  logic [TSW:0] done_q[$];

  snn_timestep_scheduler #(
    .NUM_NEURONS(NN), .TIMESTEP_WIDTH(TSW), .TIMEOUT_WIDTH(TOW)
  ) dut (
    .aclk(aclk), .rst(rst), .start(start), .abort(abort),
    .num_timesteps(num_timesteps), .drain_timeout(drain_timeout),
    .in_frame_last(in_frame_last), .inject_en(inject_en),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_id(upd_id), .upd_last(upd_last),
    .router_empty(router_empty), .out_fifo_empty(out_fifo_empty),
    .busy(busy), .done_irq(done_irq), .timeout_err(timeout_err),
    .cur_timestep(cur_timestep), .state(state)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake and every completion pulse must match the next queued entry.
  always @(negedge aclk) begin
    if (upd_valid && upd_ready) begin
      if (upd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL upd_unexpected: got id %0d with nothing expected", upd_id);
      end else begin
        int e;
        e = upd_q.pop_front();
        check("upd_id", 32'(upd_id), 32'(e));
        check("upd_last", 32'(upd_last), 32'(e == NN - 1));
      end
    end
    if (done_irq) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected: got done_irq with ts=%0d", cur_timestep);
      end else begin
        logic [TSW:0] e;
        e = done_q.pop_front();
        check("done_status", 32'({timeout_err, cur_timestep}), 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_sweep();
    for (int i = 0; i < NN; i++) upd_q.push_back(i);
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, input string name);
    int n = 0;
    while (state !== s && n < max) begin
      tick();
      n++;
    end
    check(name, 32'(state), 32'(s));
  endtask

  task automatic do_start(input int nts, input int tmo);
    num_timesteps = TSW'(nts);
    drain_timeout = TOW'(tmo);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called on the first INJECT cycle; frame ends on INJECT cycle inj_cycles.
  task automatic do_frame(input int inj_cycles);
    repeat (inj_cycles - 1) tick();
    in_frame_last = 1'b1;
    tick();
    in_frame_last = 1'b0;
    check("enter_update", 32'(state), 32'(S_UPDATE));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(state), 32'(S_IDLE));
    check({tag, "_inject_en"}, 32'(inject_en), 0);
    check({tag, "_upd_valid"}, 32'(upd_valid), 0);
    check({tag, "_upd_id"}, 32'(upd_id), 0);
    check({tag, "_upd_last"}, 32'(upd_last), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done_irq"}, 32'(done_irq), 0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 0);
    check({tag, "_cur_ts"}, 32'(cur_timestep), 0);
  endtask

  initial begin
    logic pat[7];
    int hs;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Nominal run: 2 timesteps, 9 cycles each
    push_sweep(); push_sweep();
    done_q.push_back({1'b0, 16'd2});
    do_start(2, 0);
    t0 = cyc;
    check("nom_inject_state", 32'(state), 32'(S_INJECT));
    check("nom_inject_en", 32'(inject_en), 1);
    check("nom_busy", 32'(busy), 1);
    do_frame(3);
    check("nom_upd_valid", 32'(upd_valid), 1);
    check("nom_first_id", 32'(upd_id), 0);
    wait_state(S_STEP, 20, "nom_reach_step");
    check("nom_ts_in_step", 32'(cur_timestep), 0);
    tick();
    check("nom_back_inject", 32'(state), 32'(S_INJECT));
    check("nom_step1_cycles", 32'(cyc - t0), 9);
    check("nom_ts1", 32'(cur_timestep), 1);
    t0 = cyc;
    do_frame(3);
    wait_state(S_DONE, 20, "nom_reach_done");
    check("nom_step2_cycles", 32'(cyc - t0), 9);
    check("nom_done_irq", 32'(done_irq), 1);
    check("nom_busy_in_done", 32'(busy), 1);
    tick();
    check("nom_idle", 32'(state), 32'(S_IDLE));
    check("nom_busy_low", 32'(busy), 0);
    check("nom_ts_final", 32'(cur_timestep), 2);

    // Backpressure: ready pattern 1,0,0,1,0,1,1
    push_sweep();
    done_q.push_back({1'b0, 16'd1});
    do_start(1, 0);
    do_frame(1);
    hs = 0;
    for (int i = 0; i < 7; i++) begin
      upd_ready = pat[i];
      check("bp_state_update", 32'(state), 32'(S_UPDATE));
      check("bp_id_stable", 32'(upd_id), 32'(hs));
      tick();
      if (pat[i]) hs++;
    end
    upd_ready = 1'b1;
    check("bp_drain_after_last", 32'(state), 32'(S_DRAIN));
    wait_state(S_IDLE, 10, "bp_idle");

    // Drain timeout fires on the 10th DRAIN cycle
    push_sweep();
    done_q.push_back({1'b1, 16'd0});
    router_empty = 1'b0;
    do_start(2, 10);
    do_frame(1);
    wait_state(S_DRAIN, 10, "tmo_reach_drain");
    t0 = cyc;
    wait_state(S_DONE, 20, "tmo_reach_done");
    check("tmo_drain_cycles", 32'(cyc - t0), 10);
    check("tmo_err", 32'(timeout_err), 1);
    check("tmo_ts", 32'(cur_timestep), 0);
    tick();
    check("tmo_idle", 32'(state), 32'(S_IDLE));
    check("tmo_err_sticky", 32'(timeout_err), 1);

    // Empties rise on the 10th DRAIN cycle: STEP wins over timeout
    push_sweep();
    done_q.push_back({1'b0, 16'd1});
    do_start(1, 10);
    check("tmo2_err_cleared", 32'(timeout_err), 0);
    do_frame(1);
    wait_state(S_DRAIN, 10, "tmo2_reach_drain");
    repeat (9) tick();
    check("tmo2_still_drain", 32'(state), 32'(S_DRAIN));
    router_empty = 1'b1;
    tick();
    check("tmo2_step", 32'(state), 32'(S_STEP));
    check("tmo2_no_err", 32'(timeout_err), 0);
    wait_state(S_IDLE, 10, "tmo2_idle");

    // Abort in the second timestep at upd_id=2
    push_sweep();
    upd_q.push_back(0); upd_q.push_back(1);
    do_start(3, 0);
    do_frame(1);
    wait_state(S_INJECT, 20, "ab_second_inject");
    do_frame(1);
    tick(); tick();
    check("ab_id2", 32'(upd_id), 2);
    upd_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    upd_ready = 1'b1;
    check("ab_idle", 32'(state), 32'(S_IDLE));
    check("ab_upd_valid", 32'(upd_valid), 0);
    check("ab_busy", 32'(busy), 0);
    check("ab_ts_held", 32'(cur_timestep), 1);
    repeat (3) tick();
    push_sweep();
    done_q.push_back({1'b0, 16'd1});
    do_start(1, 0);
    check("ab_restart_inject", 32'(state), 32'(S_INJECT));
    check("ab_restart_ts", 32'(cur_timestep), 0);
    do_frame(1);
    wait_state(S_IDLE, 20, "ab_restart_idle");

    // Start with zero timesteps is ignored
    do_start(0, 0);
    check("zero_start_idle", 32'(state), 32'(S_IDLE));
    check("zero_start_busy", 32'(busy), 0);

    // Start during DRAIN is ignored (limit stays 1)
    push_sweep();
    done_q.push_back({1'b0, 16'd1});
    router_empty = 1'b0;
    do_start(1, 0);
    do_frame(1);
    wait_state(S_DRAIN, 10, "ds_reach_drain");
    do_start(5, 0);
    check("ds_still_drain", 32'(state), 32'(S_DRAIN));
    router_empty = 1'b1;
    wait_state(S_DONE, 10, "ds_done");
    check("ds_ts", 32'(cur_timestep), 1);
    tick();

    // Reset mid-UPDATE
    upd_q.push_back(0); upd_q.push_back(1);
    do_start(1, 0);
    do_frame(1);
    tick();
    check("rst_pre_id", 32'(upd_id), 1);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    tick(); tick();

    check("upd_q_drained", 32'(upd_q.size()), 0);
    check("done_q_drained", 32'(done_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
